// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory port A arbiter.
// Optional write protection is enabled with DMEM_WRITE_PROTECT_EN.
package dmem_pkg;

  localparam int LANES      = 4;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = LANES * 8;
  localparam int MAX_WAIT_D = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DBG  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_rd_return.sv
// Read return path: one-cycle rvalid/owner pipe and per-requester
// read-data hold registers with same-cycle bypass of the lane RAM data.
module dmem_rd_return
  import dmem_pkg::*;
#(
  parameter int DATA = DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_acc,
  input  owner_e          rd_owner,
  input  logic [DATA-1:0] ram_rdata,
  output logic            cpu_rvalid,
  output logic [DATA-1:0] cpu_rdata,
  output logic            dbg_rvalid,
  output logic [DATA-1:0] dbg_rdata
);

  logic            pend_q, pend_d;
  owner_e          own_q, own_d;
  logic [DATA-1:0] cpu_hold_q, cpu_hold_d;
  logic [DATA-1:0] dbg_hold_q, dbg_hold_d;

  always_comb begin
    pend_d = rd_acc;
    own_d  = rd_acc ? rd_owner : own_q;
  end

  assign cpu_rvalid = pend_q && (own_q == OWN_CPU);
  assign dbg_rvalid = pend_q && (own_q == OWN_DBG);

  // RAM data is only valid during the rvalid cycle; hold it afterwards.
  assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_hold_q;
  assign dbg_rdata = dbg_rvalid ? ram_rdata : dbg_hold_q;

  always_comb begin
    cpu_hold_d = cpu_rdata;
    dbg_hold_d = dbg_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 1'b0;
      own_q      <= OWN_CPU;
      cpu_hold_q <= '0;
      dbg_hold_q <= '0;
    end else begin
      pend_q     <= pend_d;
      own_q      <= own_d;
      cpu_hold_q <= cpu_hold_d;
      dbg_hold_q <= dbg_hold_d;
    end
  end

endmodule

// File: rtl/dmem_lane_arbiter.sv
// CPU / debug arbiter for data-memory port A (four byte-lane RAMs).
// Define DMEM_WRITE_PROTECT_EN to block CPU writes below PROT_TOP.
module dmem_lane_arbiter
  import dmem_pkg::*;
#(
  parameter int              ADDR     = ADDR_W,
  parameter int              DATA     = DATA_W,
  parameter int              MAX_WAIT = MAX_WAIT_D,
  parameter logic [ADDR-1:0] PROT_TOP = 'h100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [ADDR-1:0]  cpu_addr,
  input  logic [LANES-1:0] cpu_be,
  input  logic [DATA-1:0]  cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_rvalid,
  output logic [DATA-1:0]  cpu_rdata,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [ADDR-1:0]  dbg_addr,
  input  logic [LANES-1:0] dbg_be,
  input  logic [DATA-1:0]  dbg_wdata,
  input  logic             dbg_lock,
  output logic             dbg_gnt,
  output logic             dbg_rvalid,
  output logic [DATA-1:0]  dbg_rdata,
  output logic             ram_ce,
  output logic [LANES-1:0] ram_we,
  output logic [ADDR-1:0]  ram_addr,
  output logic [DATA-1:0]  ram_wdata,
  input  logic [DATA-1:0]  ram_rdata,
  output logic             prot_err
);

  localparam int            CW   = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          force_dbg;
  logic          rd_acc;
  owner_e        rd_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Grants are combinational; reset masks them so outputs drop at once.
  always_comb begin
    force_dbg = dbg_req && (wcnt_q == CMAX);
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    case (state_q)
      DBG: begin
        dbg_gnt = dbg_req;
        cpu_gnt = cpu_req && !dbg_req && !dbg_lock;
      end
      default: begin
        cpu_gnt = cpu_req && !force_dbg;
        dbg_gnt = dbg_req && !cpu_gnt;
      end
    endcase
    if (rst) begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DBG: begin
        if (dbg_lock)     state_d = DBG;
        else if (cpu_gnt) state_d = CPU;
        else              state_d = IDLE;
      end
      default: begin
        if (cpu_gnt)      state_d = CPU;
        else if (dbg_gnt) state_d = DBG;
        else              state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (dbg_gnt)
      wcnt_d = '0;
    else if (dbg_req && (wcnt_q != CMAX))
      wcnt_d = wcnt_q + 1'b1;
  end

  always_comb begin
    ram_ce    = cpu_gnt || dbg_gnt;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_be & {LANES{cpu_we}};
    end else if (dbg_gnt) begin
      ram_addr  = dbg_addr;
      ram_wdata = dbg_wdata;
      ram_we    = dbg_be & {LANES{dbg_we}};
    end
`ifdef DMEM_WRITE_PROTECT_EN
    if (cpu_gnt && cpu_we && (cpu_addr < PROT_TOP))
      ram_we = '0;
`endif
  end

`ifdef DMEM_WRITE_PROTECT_EN
  logic prot_err_q, prot_err_d;

  always_comb begin
    prot_err_d = prot_err_q;
    if (cpu_gnt && cpu_we && (cpu_addr < PROT_TOP))
      prot_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prot_err_q <= 1'b0;
    else     prot_err_q <= prot_err_d;
  end

  assign prot_err = prot_err_q;
`else
  assign prot_err = 1'b0;
`endif

  assign rd_acc   = (cpu_gnt && !cpu_we) || (dbg_gnt && !dbg_we);
  assign rd_owner = dbg_gnt ? OWN_DBG : OWN_CPU;

  dmem_rd_return #(
    .DATA(DATA)
  ) u_rd_return (
    .clk       (clk),
    .rst       (rst),
    .rd_acc    (rd_acc),
    .rd_owner  (rd_owner),
    .ram_rdata (ram_rdata),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata)
  );

endmodule
